ps2_kbd_ctrl: RTL and testbench

- Keyboard-side sequencer sitting between the PS/2 receive path (byte + ready pulse) and a host-to-device transmitter.
- Runs the power-up reset/BAT handshake, services LED-update requests with ACK/resend/timeout handling, and forwards all other received bytes as key bytes.
- Single clock domain; the top level instantiates it between the receiver, the transmitter and user logic.

---
 rtl/ps2_kbd_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// Keyboard-side PS/2 sequencer: power-up reset/BAT handshake, LED updates with
// ACK/resend/timeout handling, and forwarding of all other received bytes.
module ps2_kbd_ctrl #(
  parameter int unsigned POWERUP_CYC = 50000000,
  parameter int unsigned ACK_TIMEOUT = 2000000,
  parameter int unsigned BAT_TIMEOUT = 100000000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       init_req,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic       kbd_ready,
  output logic       kbd_fail
);

  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BAT_LAST   = CNT_W'(BAT_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT  = RTY_W'(MAX_RETRY);

  localparam logic [7:0] CMD_RST     = 8'hFF;
  localparam logic [7:0] CMD_LED     = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_TX,
    ST_TX_WAIT,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_READY,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    BY_RST,
    BY_LEDCMD,
    BY_LEDVAL
  } byte_t;

  state_t           state_q,     state_d;
  byte_t            byte_sel_q,  byte_sel_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [RTY_W-1:0] retry_q,     retry_d;
  logic             tx_start_q,  tx_start_d;
  logic [7:0]       tx_data_q,   tx_data_d;
  logic [7:0]       key_data_q,  key_data_d;
  logic             key_valid_q, key_valid_d;
  logic             kbd_ready_q, kbd_ready_d;
  logic             kbd_fail_q,  kbd_fail_d;
  logic [2:0]       led_reg_q,   led_reg_d;
  logic             led_pend_q,  led_pend_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [RTY_W-1:0] retry_inc;
  logic             retry_over;
  logic             consume;

  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign retry_inc  = retry_q + RTY_W'(1);
  assign retry_over = (retry_inc > RTY_LIMIT);

  // Next-state, command byte selection, retry/timeout and forwarding decisions.
  always_comb begin
    state_d     = state_q;
    byte_sel_d  = byte_sel_q;
    cnt_d       = cnt_inc;
    retry_d     = retry_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    key_data_d  = key_data_q;
    key_valid_d = 1'b0;
    led_reg_d   = led_reg_q;
    led_pend_d  = led_pend_q;
    consume     = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q >= PWR_LAST) begin
          state_d    = ST_TX;
          byte_sel_d = BY_RST;
          tx_data_d  = CMD_RST;
          retry_d    = {RTY_W{1'b0}};
        end else begin
          state_d = ST_PWRUP;
        end
      end

      ST_TX: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_TX_WAIT;
        end else begin
          state_d = ST_TX;
        end
      end

      ST_TX_WAIT: begin
        if (tx_done) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_TX_WAIT;
        end
      end

      // A received byte always takes precedence over a coincident timeout.
      ST_WAIT_ACK: begin
        if (rx_ready) begin
          if (rx_data == RSP_ACK) begin
            consume = 1'b1;
            retry_d = {RTY_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            case (byte_sel_q)
              BY_RST:    state_d = ST_WAIT_BAT;
              BY_LEDCMD: begin
                state_d    = ST_TX;
                byte_sel_d = BY_LEDVAL;
                tx_data_d  = {5'b00000, led_reg_q};
              end
              BY_LEDVAL: state_d = ST_READY;
              default:   state_d = ST_FAIL;
            endcase
          end else if (rx_data == RSP_RESEND) begin
            consume = 1'b1;
            retry_d = retry_inc;
            state_d = retry_over ? ST_FAIL : ST_TX;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end else if (cnt_q >= ACK_LAST) begin
          retry_d = retry_inc;
          state_d = retry_over ? ST_FAIL : ST_TX;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_BAT: begin
        if (rx_ready) begin
          if (rx_data == RSP_BAT_OK) begin
            consume = 1'b1;
            state_d = ST_READY;
          end else if (rx_data == RSP_BAT_ERR) begin
            consume    = 1'b1;
            retry_d    = retry_inc;
            byte_sel_d = BY_RST;
            tx_data_d  = CMD_RST;
            state_d    = retry_over ? ST_FAIL : ST_TX;
          end else begin
            state_d = ST_WAIT_BAT;
          end
        end else if (cnt_q >= BAT_LAST) begin
          retry_d    = retry_inc;
          byte_sel_d = BY_RST;
          tx_data_d  = CMD_RST;
          state_d    = retry_over ? ST_FAIL : ST_TX;
        end else begin
          state_d = ST_WAIT_BAT;
        end
      end

      ST_READY: begin
        if (init_req) begin
          state_d    = ST_TX;
          byte_sel_d = BY_RST;
          tx_data_d  = CMD_RST;
          retry_d    = {RTY_W{1'b0}};
        end else if (led_pend_q) begin
          led_pend_d = 1'b0;
          state_d    = ST_TX;
          byte_sel_d = BY_LEDCMD;
          tx_data_d  = CMD_LED;
        end else begin
          state_d = ST_READY;
        end
      end

      ST_FAIL: begin
        if (init_req) begin
          state_d    = ST_TX;
          byte_sel_d = BY_RST;
          tx_data_d  = CMD_RST;
          retry_d    = {RTY_W{1'b0}};
        end else begin
          state_d = ST_FAIL;
        end
      end

      default: begin
        state_d = ST_PWRUP;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    if (rx_ready && !consume) begin
      key_valid_d = 1'b1;
      key_data_d  = rx_data;
    end else begin
      key_valid_d = 1'b0;
    end

    // Applied after the state case so a new request re-arms a pending flag being serviced.
    if (led_req) begin
      led_reg_d  = led_val;
      led_pend_d = 1'b1;
    end else begin
      led_reg_d = led_reg_q;
    end

    kbd_ready_d = (state_d == ST_READY);
    kbd_fail_d  = (state_d == ST_FAIL);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PWRUP;
      byte_sel_q  <= BY_RST;
      cnt_q       <= {CNT_W{1'b0}};
      retry_q     <= {RTY_W{1'b0}};
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      key_data_q  <= 8'h00;
      key_valid_q <= 1'b0;
      kbd_ready_q <= 1'b0;
      kbd_fail_q  <= 1'b0;
      led_reg_q   <= 3'b000;
      led_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_sel_q  <= byte_sel_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      key_data_q  <= key_data_d;
      key_valid_q <= key_valid_d;
      kbd_ready_q <= kbd_ready_d;
      kbd_fail_q  <= kbd_fail_d;
      led_reg_q   <= led_reg_d;
      led_pend_q  <= led_pend_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign key_data  = key_data_q;
  assign key_valid = key_valid_q;
  assign kbd_ready = kbd_ready_q;
  assign kbd_fail  = kbd_fail_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: behavioural transmitter/receiver driven
// from tasks, table-driven forwarding/LED vectors and randomized traffic.
module tb_ps2_kbd_ctrl;

  localparam int PWR  = 100;
  localparam int ACKT = 1000;
  localparam int BATT = 5000;
  localparam int MR   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       led_req;
  logic [2:0] led_val;
  logic       init_req;
  logic [7:0] key_data;
  logic       key_valid;
  logic       kbd_ready;
  logic       kbd_fail;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_txs = 0;
  int n_key = 0;
  int exp_key = 0;

  typedef struct { logic [2:0] led; logic [7:0] exp_byte; } led_vec_t;
  typedef struct { logic [7:0] rx;  logic exp_fwd; }        fwd_vec_t;
  typedef enum { PH_ACK, PH_BAT, PH_OTHER } phase_t;

  ps2_kbd_ctrl #(
    .POWERUP_CYC(PWR), .ACK_TIMEOUT(ACKT), .BAT_TIMEOUT(BATT),
    .MAX_RETRY(MR), .CNT_W(27)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .led_req(led_req), .led_val(led_val), .init_req(init_req),
    .key_data(key_data), .key_valid(key_valid), .kbd_ready(kbd_ready), .kbd_fail(kbd_fail)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (tx_start === 1'b1) n_txs++;
    if (key_valid === 1'b1) n_key++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // Protocol rule: which response bytes are swallowed in which waiting phase.
  function automatic bit is_consumed(input phase_t p, input logic [7:0] b);
    case (p)
      PH_ACK:  return (b == 8'hFA) || (b == 8'hFE);
      PH_BAT:  return (b == 8'hAA) || (b == 8'hFC);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_tx(input logic [7:0] exp, input int budget, input string nm, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        at = cyc;
        tx_busy = 1'b1;
        break;
      end
    end
    check({nm, "_seen"}, (at >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (at >= 0) check({nm, "_data"}, 32'(tx_data), 32'(exp));
  endtask

  task automatic finish_tx(output int done_edge);
    repeat (3) tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    done_edge = cyc;
  endtask

  task automatic rx_byte(input logic [7:0] b, output int e);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    e = cyc;
  endtask

  task automatic fwd_check(input string nm, input phase_t p, input logic [7:0] b);
    int e;
    bit fwd;
    fwd = !is_consumed(p, b);
    rx_byte(b, e);
    check({nm, "_valid"}, 32'(key_valid), 32'(fwd));
    if (fwd) begin
      exp_key++;
      check({nm, "_data"}, 32'(key_data), 32'(b));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;
    led_req = 1'b0; led_val = 3'b000; init_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pulse_init();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic init_seq(input string nm);
    int at, d, e;
    expect_tx(8'hFF, PWR + 10, {nm, "_rst"}, at);
    finish_tx(d);
    rx_byte(8'hFA, e);
    rx_byte(8'hAA, e);
    tick();
    check({nm, "_ready"}, 32'(kbd_ready), 32'd1);
  endtask

  task automatic led_seq(input logic [2:0] v, input logic [7:0] expv, input string nm);
    int at, d, e;
    led_val = v;
    led_req = 1'b1;
    tick();
    led_req = 1'b0;
    expect_tx(8'hED, 10, {nm, "_cmd"}, at);
    finish_tx(d);
    rx_byte(8'hFA, e);
    expect_tx(expv, 10, {nm, "_val"}, at);
    finish_tx(d);
    rx_byte(8'hFA, e);
    tick();
    check({nm, "_ready"}, 32'(kbd_ready), 32'd1);
  endtask

  initial begin
    led_vec_t led_tab[4];
    fwd_vec_t fwd_tab[7];
    int at, d, e, rel, base;
    logic [7:0] b;
    logic [2:0] v;

    led_tab[0] = '{3'b101, 8'h05};
    led_tab[1] = '{3'b000, 8'h00};
    led_tab[2] = '{3'b111, 8'h07};
    led_tab[3] = '{3'b010, 8'h02};
    fwd_tab[0] = '{8'h1C, 1'b1};
    fwd_tab[1] = '{8'hF0, 1'b1};
    fwd_tab[2] = '{8'h1C, 1'b1};
    fwd_tab[3] = '{8'hFA, 1'b1};
    fwd_tab[4] = '{8'hAA, 1'b1};
    fwd_tab[5] = '{8'hFE, 1'b1};
    fwd_tab[6] = '{8'hFC, 1'b1};

    // 1. Reset values and clean init.
    apply_reset();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_data", 32'(key_data), 32'd0);
    check("rst_ready", 32'(kbd_ready), 32'd0);
    check("rst_fail", 32'(kbd_fail), 32'd0);
    rst = 1'b0;
    rel = cyc;
    base = n_txs;
    expect_tx(8'hFF, PWR + 10, "pwrup", at);
    check("pwrup_time", at, rel + PWR + 1);
    finish_tx(d);
    rx_byte(8'hFA, e);
    check("bat_wait_not_ready", 32'(kbd_ready), 32'd0);
    rx_byte(8'hAA, e);
    tick();
    check("init_ready", 32'(kbd_ready), 32'd1);
    check("init_fail", 32'(kbd_fail), 32'd0);
    check("init_txcount", n_txs - base, 1);
    check("init_no_keys", n_key, 0);

    // 2a. Two resends then success.
    apply_reset();
    rst = 1'b0;
    base = n_txs;
    expect_tx(8'hFF, PWR + 10, "rs_tx1", at);
    finish_tx(d); rx_byte(8'hFE, e);
    expect_tx(8'hFF, 10, "rs_tx2", at);
    finish_tx(d); rx_byte(8'hFE, e);
    expect_tx(8'hFF, 10, "rs_tx3", at);
    finish_tx(d); rx_byte(8'hFA, e); rx_byte(8'hAA, e);
    tick();
    check("rs_ready", 32'(kbd_ready), 32'd1);
    check("rs_txcount", n_txs - base, 3);

    // 2b. Three resends exhaust the retry budget.
    apply_reset();
    rst = 1'b0;
    base = n_txs;
    for (int i = 0; i < 3; i++) begin
      expect_tx(8'hFF, PWR + 10, "rf_tx", at);
      finish_tx(d);
      rx_byte(8'hFE, e);
    end
    tick();
    check("rf_fail", 32'(kbd_fail), 32'd1);
    check("rf_not_ready", 32'(kbd_ready), 32'd0);
    repeat (ACKT + 50) tick();
    check("rf_no_4th_tx", n_txs - base, 3);
    check("rf_fail_held", 32'(kbd_fail), 32'd1);

    // 6a. Recovery from FAIL via init_req.
    pulse_init();
    init_seq("recover1");
    check("recover1_fail_clr", 32'(kbd_fail), 32'd0);

    // 3. LED updates, table-driven.
    for (int i = 0; i < 4; i++) led_seq(led_tab[i].led, led_tab[i].exp_byte, $sformatf("led%0d", i));

    // 3b. Two requests while the value byte awaits its ACK: one follow-up update with the last value.
    base = n_txs;
    led_val = 3'b101; led_req = 1'b1; tick(); led_req = 1'b0;
    expect_tx(8'hED, 10, "dbl_cmd1", at); finish_tx(d); rx_byte(8'hFA, e);
    expect_tx(8'h05, 10, "dbl_val1", at); finish_tx(d);
    led_val = 3'b001; led_req = 1'b1; tick();
    led_val = 3'b110; tick(); led_req = 1'b0;
    rx_byte(8'hFA, e);
    expect_tx(8'hED, 10, "dbl_cmd2", at); finish_tx(d); rx_byte(8'hFA, e);
    expect_tx(8'h06, 10, "dbl_val2", at); finish_tx(d); rx_byte(8'hFA, e);
    repeat (30) tick();
    check("dbl_ready", 32'(kbd_ready), 32'd1);
    check("dbl_txcount", n_txs - base, 4);

    // 4. ACK timeout on the LED command.
    led_val = 3'b011; led_req = 1'b1; tick(); led_req = 1'b0;
    expect_tx(8'hED, 10, "ackto_cmd", at);
    finish_tx(d);
    expect_tx(8'hED, ACKT + 10, "ackto_resend", at);
    check("ackto_time", at, d + ACKT + 1);
    finish_tx(d); rx_byte(8'hFA, e);
    expect_tx(8'h03, 10, "ackto_val", at);
    finish_tx(d); rx_byte(8'hFA, e);
    tick();
    check("ackto_ready", 32'(kbd_ready), 32'd1);

    // 4b. BAT timeout re-sends reset.
    pulse_init();
    expect_tx(8'hFF, 10, "batto_rst", at);
    finish_tx(d); rx_byte(8'hFA, e);
    expect_tx(8'hFF, BATT + 10, "batto_resend", at);
    check("batto_time", at, e + BATT + 1);
    finish_tx(d); rx_byte(8'hFA, e); rx_byte(8'hAA, e);
    tick();
    check("batto_ready", 32'(kbd_ready), 32'd1);

    // 4c. No replies at all: retries exhausted by timeouts.
    base = n_txs;
    pulse_init();
    expect_tx(8'hFF, 10, "exh_tx1", at);
    finish_tx(d);
    for (int i = 0; i < 2; i++) begin
      expect_tx(8'hFF, ACKT + 10, "exh_retx", at);
      check("exh_time", at, d + ACKT + 1);
      finish_tx(d);
    end
    repeat (ACKT + 20) tick();
    check("exh_fail", 32'(kbd_fail), 32'd1);
    check("exh_txcount", n_txs - base, 3);
    pulse_init();
    init_seq("recover2");

    // 5. Forwarding in READY, table-driven, then in WAIT_ACK.
    for (int i = 0; i < 7; i++) begin
      fwd_check($sformatf("fwd%0d", i), PH_OTHER, fwd_tab[i].rx);
      check($sformatf("fwd%0d_tab", i), 32'(!is_consumed(PH_OTHER, fwd_tab[i].rx)), 32'(fwd_tab[i].exp_fwd));
      tick();
      check($sformatf("fwd%0d_pulse", i), 32'(key_valid), 32'd0);
    end
    led_val = 3'b100; led_req = 1'b1; tick(); led_req = 1'b0;
    expect_tx(8'hED, 10, "wa_cmd", at); finish_tx(d);
    fwd_check("wa_1c", PH_ACK, 8'h1C);
    check("wa_not_ready", 32'(kbd_ready), 32'd0);
    rx_byte(8'hFA, e);
    expect_tx(8'h04, 10, "wa_val", at); finish_tx(d); rx_byte(8'hFA, e);
    tick();
    check("wa_ready", 32'(kbd_ready), 32'd1);

    // Randomized traffic against the forwarding rule model.
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick();
      fwd_check("rnd_ready", PH_OTHER, b);
    end
    pulse_init();
    expect_tx(8'hFF, 10, "rnd_bat_rst", at); finish_tx(d); rx_byte(8'hFA, e);
    for (int i = 0; i < 10; i++) begin
      do b = 8'($urandom_range(0, 255)); while (is_consumed(PH_BAT, b));
      fwd_check("rnd_bat", PH_BAT, b);
    end
    rx_byte(8'hAA, e);
    tick();
    check("rnd_bat_ready", 32'(kbd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      v = 3'($urandom_range(0, 7));
      led_seq(v, {5'b00000, v}, "rnd_led");
    end
    check("key_pulse_count", n_key, exp_key);

    // 6b. Reset in the middle of a transmit.
    led_val = 3'b001; led_req = 1'b1; tick(); led_req = 1'b0;
    expect_tx(8'hED, 10, "mid_cmd", at);
    tick();
    rst = 1'b1;
    tick();
    check("mid_tx_start", 32'(tx_start), 32'd0);
    check("mid_tx_data", 32'(tx_data), 32'd0);
    check("mid_key_data", 32'(key_data), 32'd0);
    check("mid_ready", 32'(kbd_ready), 32'd0);
    check("mid_fail", 32'(kbd_fail), 32'd0);
    tx_busy = 1'b0;
    rst = 1'b0;
    rel = cyc;
    expect_tx(8'hFF, PWR + 10, "mid_pwrup", at);
    check("mid_pwrup_time", at, rel + PWR + 1);
    finish_tx(d); rx_byte(8'hFA, e); rx_byte(8'hAA, e);
    tick();
    check("mid_ready_again", 32'(kbd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
